// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-2 message-schedule generator (SHA-224/256 and SHA-384/512).
//
// The block takes one 16-word message block. It then emits W_0 .. W_{ROUNDS-1},
// one word per accepted output handshake.
//
// The schedule is held in a 16-entry shift register. s_q[0] is the oldest word
// and is always the word currently presented on w_data. Each accepted word
// shifts the window by one and appends the next recurrence word at s_q[15].
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   blk_data   in   16*WORD_W message block, word 0 in the MSBs
//   blk_valid  in   blk_data valid
//   blk_ready  out  block accepted on blk_valid && blk_ready
//   w_data     out  current schedule word W_t
//   w_idx      out  t of w_data
//   w_valid    out  w_data / w_idx valid
//   w_ready    in   consumer accepts on w_valid && w_ready
//   w_last     out  high with w_valid when t == ROUNDS-1
module sha2_msg_sched #(
  parameter int  WORD_W = 32,
  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64,
  localparam int IDX_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [16*WORD_W-1:0]  blk_data,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  output logic [WORD_W-1:0]     w_data,
  output logic [IDX_W-1:0]      w_idx,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last
);

  // Only the two SHA-2 word widths have defined sigma functions.
  if ((WORD_W != 32) && (WORD_W != 64)) begin : g_bad_word_w
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end

  localparam logic             ST_IDLE  = 1'b0;
  localparam logic             ST_RUN   = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    end else begin
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    end
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    end else begin
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    end
  endfunction

  logic              state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] s_q [16];
  logic [WORD_W-1:0] s_d [16];
  logic [WORD_W-1:0] next_word;
  logic              run;
  logic              last;
  logic              w_hs;
  logic              blk_hs;

  assign run  = (state_q == ST_RUN);
  assign last = run && (cnt_q == LAST_IDX);
  assign w_hs = run && w_ready;

  // Accept a new block while idle, or during the final word's handshake.
  // The second case gives back-to-back blocks with no bubble.
  assign blk_ready = (state_q == ST_IDLE) || (last && w_ready);
  assign blk_hs    = blk_valid && blk_ready;

  // Recurrence word t+16 from the current window (s_q[k] holds W_{t+k}).
  // The sum wraps modulo 2^WORD_W.
  always_comb begin
    next_word = sigma1(s_q[14]) + s_q[9] + sigma0(s_q[1]) + s_q[0];
  end

  // Next-state logic. A block load takes priority, so a final-word handshake
  // with a simultaneous block load stays in RUN at cnt 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 16; i++) begin
      s_d[i] = s_q[i];
    end
    if (blk_hs) begin
      for (int i = 0; i < 16; i++) begin
        s_d[i] = blk_data[(16-i)*WORD_W-1 -: WORD_W];
      end
      cnt_d   = '0;
      state_d = ST_RUN;
    end else if (w_hs) begin
      if (last) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        for (int i = 0; i < 15; i++) begin
          s_d[i] = s_q[i+1];
        end
        s_d[15] = next_word;
        cnt_d   = cnt_q + 7'd1;
      end
    end else begin
      // Stalled or idle: everything holds, so w_data and w_idx stay stable.
      state_d = state_q;
    end
  end

  // State registers with synchronous reset. Reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        s_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 16; i++) begin
        s_q[i] <= s_d[i];
      end
    end
  end

  assign w_data  = s_q[0];
  assign w_idx   = cnt_q;
  assign w_valid = run;
  assign w_last  = last;

endmodule
